constant_display: RTL

//  Read-back sequencer for the Julia-set constants: once the entry menu finishes, latches
//  the 32-bit real/imaginary constants and replays them 16 bits at a time on the board display.
//  The operator steps through the four words with the same select button used for entry
//  (press = select low, advance on release). Entry and display order match:
//  rC msb, rC lsb, iC msb, iC lsb.

---
 rtl/constant_display_if.sv | 23 ++
 rtl/constant_display.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/constant_display_if.sv
// Bus between the constant-entry menu / button / display driver and the read-back sequencer.
// master = the side that supplies constants and the button, slave = constant_display.
interface constant_display_if;
    logic        load;
    logic [31:0] rC;
    logic [31:0] iC;
    logic        select;
    logic [15:0] disp;
    logic [1:0]  word_idx;
    logic        valid;
    logic        done;
    logic [1:0]  S;

    modport master (
        output load, rC, iC, select,
        input  disp, word_idx, valid, done, S
    );

    modport slave (
        input  load, rC, iC, select,
        output disp, word_idx, valid, done, S
    );
endinterface

// File: rtl/constant_display.sv
// Latches the Julia-set constants when the entry menu finishes and replays them as four 16-bit
// words, stepped by the debounced select button. Macro AUTO_SCROLL_EN adds timed auto-advance.
module constant_display #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter logic [31:0] DWELL      = 32'd50000000
) (
    input  logic               clk,
    input  logic               rst,
    constant_display_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SHOW = 2'b01,
        HELD = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] disp_q, disp_d;
    logic [1:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic [31:0] rc_q, rc_d;
    logic [31:0] ic_q, ic_d;
    logic        advance;

    logic        sync1_q, sync2_q;
    logic        filt_q;
    logic [15:0] deb_cnt_q;

    function automatic logic [15:0] pick_word(input logic [1:0] idx,
                                              input logic [31:0] rc,
                                              input logic [31:0] ic);
        logic [15:0] w;
        case (idx)
            2'd0:    w = rc[31:16];
            2'd1:    w = rc[15:0];
            2'd2:    w = ic[31:16];
            default: w = ic[15:0];
        endcase
        return w;
    endfunction

    // Button path: sync flops and filter idle high (button released).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            filt_q    <= 1'b1;
            deb_cnt_q <= 16'd0;
        end else begin
            sync1_q <= bus.select;
            sync2_q <= sync1_q;
            if (sync2_q == filt_q) begin
                deb_cnt_q <= 16'd0;
            end else if (deb_cnt_q == DEB_CYCLES - 16'd1) begin
                filt_q    <= sync2_q;
                deb_cnt_q <= 16'd0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 16'd1;
            end
        end
    end

`ifdef AUTO_SCROLL_EN
    logic [31:0] dwell_q, dwell_d;
`else
    logic        dwell_unused;
    assign dwell_unused = ^DWELL;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            disp_q  <= 16'd0;
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            rc_q    <= 32'd0;
            ic_q    <= 32'd0;
`ifdef AUTO_SCROLL_EN
            dwell_q <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            rc_q    <= rc_d;
            ic_q    <= ic_d;
`ifdef AUTO_SCROLL_EN
            dwell_q <= dwell_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done_d  = done_q;
        rc_d    = rc_q;
        ic_d    = ic_q;
        advance = 1'b0;
`ifdef AUTO_SCROLL_EN
        dwell_d = dwell_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    rc_d    = bus.rC;
                    ic_d    = bus.iC;
                    idx_d   = 2'd0;
                    disp_d  = bus.rC[31:16];
                    valid_d = 1'b1;
                    state_d = SHOW;
`ifdef AUTO_SCROLL_EN
                    dwell_d = 32'd0;
`endif
                end
            end
            SHOW: begin
                if (!filt_q) begin
                    state_d = HELD;
`ifdef AUTO_SCROLL_EN
                end else if (dwell_q == DWELL - 32'd1) begin
                    advance = 1'b1;
                end else begin
                    dwell_d = dwell_q + 32'd1;
`endif
                end
            end
            HELD: begin
                if (filt_q) begin
                    advance = 1'b1;
                end
            end
            default: begin
                if (!bus.load) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
        endcase

        // Release (or dwell expiry) moves to the next word, or finishes after the last one.
        if (advance) begin
            if (idx_q == 2'd3) begin
                valid_d = 1'b0;
                disp_d  = 16'd0;
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                idx_d   = idx_q + 2'd1;
                disp_d  = pick_word(idx_q + 2'd1, rc_q, ic_q);
                state_d = SHOW;
`ifdef AUTO_SCROLL_EN
                dwell_d = 32'd0;
`endif
            end
        end
    end

    assign bus.disp     = disp_q;
    assign bus.word_idx = idx_q;
    assign bus.valid    = valid_q;
    assign bus.done     = done_q;
    assign bus.S        = state_q;

endmodule
